timer_scheduler: RTL and testbench

- Shares one countdown timer among NUM_REQ requesters, e.g. I2C bit-phase sequencing, bus timeouts and retry back-off.
- Each requester asks for a delay of N cycles over a valid/ready handshake. The scheduler grants requesters round-robin, loads the timer and waits for it to expire. It then returns a one-cycle done pulse to the owning requester.
- The countdown counter is internal: load, decrement while enabled, hold at zero.

---
 rtl/timer_scheduler.sv | 135 +++++++++++++
 tb/tb_timer_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// timer_scheduler: one countdown timer shared round-robin among NUM_REQ
// requesters. A requester hands over a delay over valid/ready, the timer is
// loaded and counted down, and the owner receives a one-cycle done pulse.
module timer_scheduler #(
  parameter  int NUM_REQ   = 4,
  parameter  int BIT_WIDTH = 16,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         abort,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_count,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [ID_WIDTH-1:0]          active_id,
  output logic [BIT_WIDTH-1:0]         remaining
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_e;

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] counter_q, counter_d;
  logic [BIT_WIDTH-1:0] count_q, count_d;
  logic [ID_WIDTH-1:0]  active_id_q, active_id_d;
  logic [ID_WIDTH-1:0]  last_grant_q, last_grant_d;

  logic [BIT_WIDTH-1:0] lane_count [NUM_REQ];
  logic                 grant_found;
  logic [ID_WIDTH-1:0]  winner;
  logic [ID_WIDTH-1:0]  rr_cand;

  // Unpack the flat count bus into one word per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_count[i] = req_count[i*BIT_WIDTH +: BIT_WIDTH];
  end

  // Round-robin search starting just after the last owner. The loop walks
  // from the farthest candidate to the nearest so the nearest valid one
  // is the final (winning) assignment.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    winner      = '0;
    rr_cand     = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      rr_cand = ID_WIDTH'((int'(last_grant_q) + off) % NUM_REQ);
      if (req_valid[rr_cand]) begin
        grant_found = 1'b1;
        winner      = rr_cand;
      end
    end
  end

  // Handshake and expiry strobes decoded from the registered state.
  always_comb begin
    req_ready = '0;
    done      = '0;
    if (state_q == IDLE && !abort && grant_found) begin
      req_ready = NUM_REQ'(1) << winner;
    end
    if (state_q == DONE && !abort) begin
      done = NUM_REQ'(1) << active_id_q;
    end
  end

  assign busy      = (state_q != IDLE);
  assign active_id = active_id_q;
  assign remaining = counter_q;

  // Next-state logic: grant, load, count down, report; abort overrides all.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    count_d      = count_q;
    active_id_d  = active_id_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (!abort && grant_found) begin
          count_d     = lane_count[winner];
          active_id_d = winner;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        counter_d = count_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (counter_q == '0) begin
          state_d = DONE;
        end else if (enable) begin
          counter_d = counter_q - BIT_WIDTH'(1);
        end
      end
      DONE: begin
        last_grant_d = active_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An aborted owner is treated as served so it drops to lowest priority.
    if (abort && state_q != IDLE) begin
      state_d      = IDLE;
      counter_d    = '0;
      last_grant_d = active_id_q;
    end
  end

  // State registers; last_grant resets to the top index so requester 0 wins first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      count_q      <= '0;
      active_id_q  <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other register.
      state_q      <= state_d;
      counter_q    <= counter_d;
      count_q      <= count_d;
      active_id_q  <= active_id_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler (NUM_REQ=4, BIT_WIDTH=4). Inputs are
// driven at the falling edge and outputs sampled 1 time unit later, so each
// "cycle k" below is the k-th falling edge after the request is presented.
module tb_timer_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int BIT_WIDTH = 4;

  logic                         clock = 1'b0;
  logic                         reset_n;
  logic                         enable;
  logic                         abort;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_count;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           done;
  logic                         busy;
  logic [1:0]                   active_id;
  logic [BIT_WIDTH-1:0]         remaining;

  int checks = 0;
  int errors = 0;

  timer_scheduler #(.NUM_REQ(NUM_REQ), .BIT_WIDTH(BIT_WIDTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .abort     (abort),
    .req_valid (req_valid),
    .req_count (req_count),
    .req_ready (req_ready),
    .done      (done),
    .busy      (busy),
    .active_id (active_id),
    .remaining (remaining)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_count(input int i, input logic [BIT_WIDTH-1:0] v);
    req_count[i*BIT_WIDTH +: BIT_WIDTH] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    abort     = 1'b0;
    req_valid = '0;
    req_count = '0;

    // ---- Reset state ----
    step(1); #1;
    check("rst_busy", busy, 0);
    check("rst_remaining", remaining, 0);
    check("rst_done", done, 0);
    check("rst_ready", req_ready, 0);
    check("rst_active_id", active_id, 0);
    step(1); reset_n = 1'b1;
    step(1);

    // ---- Round-robin: all valid, count=1, grant every 5 cycles ----
    req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_count(i, 4'd1);
    for (int g = 0; g < 5; g++) begin
      #1 check("rr_grant", req_ready, 1 << (g % 4));
      step(1);
      if (g == 4) req_valid = '0;
      step(3); #1;
      check("rr_done", done, 1 << (g % 4));
      check("rr_ready_while_busy", req_ready, 0);
      step(1);
    end

    // ---- Single request: requester 2, count 5 ----
    req_valid = 4'b0100; set_count(2, 4'd5); #1;
    check("single_ready_c0", req_ready, 4'b0100);
    check("single_busy_c0", busy, 0);
    step(1); req_valid = '0; #1;
    check("single_busy_c1", busy, 1);
    check("single_id_c1", active_id, 2);
    check("single_done_c1", done, 0);
    for (int k = 2; k <= 7; k++) begin
      step(1); #1;
      check("single_remaining", remaining, 7 - k);
      check("single_done_early", done, 0);
    end
    step(1); #1;
    check("single_done_c8", done, 4'b0100);
    check("single_busy_c8", busy, 1);
    step(1); #1;
    check("single_done_c9", done, 0);
    check("single_busy_c9", busy, 0);

    // ---- Zero count: requester 1, done at cycle 3 ----
    step(1);
    req_valid = 4'b0010; set_count(1, 4'd0); #1;
    check("zero_ready_c0", req_ready, 4'b0010);
    step(1); req_valid = '0;
    step(1); #1;
    check("zero_done_c2", done, 0);
    check("zero_remaining_c2", remaining, 0);
    step(1); #1;
    check("zero_done_c3", done, 4'b0010);
    step(1);

    // ---- Max count: requester 3, count 15, done at cycle 18 ----
    step(1);
    req_valid = 4'b1000; set_count(3, 4'd15); #1;
    check("max_ready_c0", req_ready, 4'b1000);
    step(1); req_valid = '0;
    step(1); #1;
    check("max_remaining_c2", remaining, 15);
    step(15); #1;
    check("max_remaining_c17", remaining, 0);
    check("max_done_c17", done, 0);
    step(1); #1;
    check("max_done_c18", done, 4'b1000);
    check("max_no_wrap_c18", remaining, 0);
    step(1);

    // ---- Enable gating: requester 0, count 4, enable low cycles 4..6 ----
    step(1);
    req_valid = 4'b0001; set_count(0, 4'd4); #1;
    check("en_ready_c0", req_ready, 4'b0001);
    step(1); req_valid = '0;
    step(1); #1;
    check("en_remaining_c2", remaining, 4);
    step(2); enable = 1'b0; #1;
    check("en_remaining_c4", remaining, 2);
    step(1); #1;
    check("en_hold_c5", remaining, 2);
    step(1); #1;
    check("en_hold_c6", remaining, 2);
    step(1); enable = 1'b1; #1;
    check("en_hold_c7", remaining, 2);
    step(1); #1;
    check("en_remaining_c8", remaining, 1);
    step(1); #1;
    check("en_done_c9", done, 0);
    step(1); #1;
    check("en_done_c10", done, 4'b0001);
    step(1);

    // ---- Abort in WAIT: requester 1 aborted at remaining=3, 2 pending ----
    step(1);
    req_valid = 4'b0110; set_count(1, 4'd5); set_count(2, 4'd2); #1;
    check("abw_ready_c0", req_ready, 4'b0010);
    step(1); req_valid = 4'b0100;
    step(3); abort = 1'b1; #1;
    check("abw_remaining_c4", remaining, 3);
    check("abw_done_c4", done, 0);
    step(1); abort = 1'b0; req_valid = 4'b0110; #1;
    check("abw_busy_c5", busy, 0);
    check("abw_remaining_c5", remaining, 0);
    check("abw_done_c5", done, 0);
    check("abw_next_winner_c5", req_ready, 4'b0100);
    step(1); req_valid = '0; #1;
    check("abw_id_c6", active_id, 2);
    step(4); #1;
    check("abw_done_c10", done, 4'b0100);
    step(1);

    // ---- Abort in IDLE suppresses ready; then async reset mid-WAIT ----
    step(1);
    req_valid = 4'b0011; set_count(0, 4'd6); set_count(1, 4'd6); abort = 1'b1; #1;
    check("abi_ready_c0", req_ready, 0);
    step(1); abort = 1'b0; #1;
    check("abi_busy_c1", busy, 0);
    check("abi_ready_c1", req_ready, 4'b0001);
    step(1); req_valid = '0; #1;
    check("abi_id_c2", active_id, 0);
    step(3); #1;
    check("ar_remaining_c5", remaining, 4);
    #2 reset_n = 1'b0; #1;
    check("ar_busy", busy, 0);
    check("ar_remaining", remaining, 0);
    check("ar_done", done, 0);
    check("ar_ready", req_ready, 0);
    check("ar_active_id", active_id, 0);
    step(1); reset_n = 1'b1;
    step(1); req_valid = 4'b1111; #1;
    check("ar_first_priority", req_ready, 4'b0001);
    step(1); req_valid = '0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
